// File: rtl/inta_sequencer_if.sv
// Signal bundle between the priority resolver / CPU side and the INTA sequencer.
interface inta_sequencer_if;
  logic [7:0] irr_req;
  logic       inta_n;
  logic [4:0] icw2_vec;
  logic       aeoi;
  logic       eoi_cmd;
  logic       seoi_cmd;
  logic [2:0] seoi_level;
  logic [7:0] isr_in;
  logic       int_out;
  logic [7:0] isr_set;
  logic [7:0] irr_clr;
  logic [7:0] int_done;
  logic [7:0] data_out;
  logic       data_oe;

  modport slave (
    input  irr_req, inta_n, icw2_vec, aeoi, eoi_cmd, seoi_cmd, seoi_level, isr_in,
    output int_out, isr_set, irr_clr, int_done, data_out, data_oe
  );

  modport master (
    output irr_req, inta_n, icw2_vec, aeoi, eoi_cmd, seoi_cmd, seoi_level, isr_in,
    input  int_out, isr_set, irr_clr, int_done, data_out, data_oe
  );
endinterface

// File: rtl/inta_sequencer.sv
// 8259-style INTA sequencer: raises INT, runs the two-pulse acknowledge, drives the
// vector byte and produces the ISR set, IRR clear and ISR clear (EOI) pulses.
module inta_sequencer (
  input logic             clk,
  input logic             rst_n,
  inta_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_e;

  state_e     state_q, state_d;
  logic       intaPrev_q;
  logic [2:0] level_q, level_d;
  logic       spurious_q, spurious_d;
  logic       intOut_q, intOut_d;
  logic       dataOe_q, dataOe_d;
  logic [7:0] dataOut_q, dataOut_d;
  logic [7:0] isrSet_q, isrSet_d;
  logic [7:0] irrClr_q, irrClr_d;
  logic [7:0] intDone_q, intDone_d;

  logic       intaFall, intaRise;
  logic [2:0] reqLevel;
  logic [7:0] eoiMask, aeoiMask;

  assign intaFall = intaPrev_q & ~bus.inta_n;
  assign intaRise = ~intaPrev_q & bus.inta_n;

  always_comb begin
    reqLevel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.irr_req[i]) reqLevel = 3'(i);
    end
  end

  // Non-specific EOI isolates the lowest-index (highest-priority) in-service bit.
  always_comb begin
    eoiMask = 8'h00;
    if (bus.seoi_cmd)
      eoiMask = 8'h01 << bus.seoi_level;
    else if (bus.eoi_cmd)
      eoiMask = bus.isr_in & (~bus.isr_in + 8'h01);
  end

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    spurious_d = spurious_q;
    intOut_d   = intOut_q;
    dataOe_d   = dataOe_q;
    dataOut_d  = dataOut_q;
    isrSet_d   = 8'h00;
    irrClr_d   = 8'h00;
    aeoiMask   = 8'h00;

    case (state_q)
      IDLE: begin
        if (bus.irr_req != 8'h00) begin
          state_d  = PEND;
          intOut_d = 1'b1;
        end
      end
      PEND: begin
        intOut_d = 1'b1;
        if (intaFall) begin
          intOut_d = 1'b0;
          state_d  = ACK1;
          // A request withdrawn before the acknowledge is answered as IR7 without touching IRR/ISR.
          if (bus.irr_req != 8'h00) begin
            level_d    = reqLevel;
            spurious_d = 1'b0;
            isrSet_d   = bus.irr_req;
            irrClr_d   = bus.irr_req;
          end else begin
            level_d    = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (intaRise) state_d = WAIT2;
      end
      WAIT2: begin
        if (intaFall) begin
          dataOut_d = {bus.icw2_vec, level_q};
          dataOe_d  = 1'b1;
          state_d   = ACK2;
        end
      end
      ACK2: begin
        if (intaRise) begin
          dataOut_d = 8'h00;
          dataOe_d  = 1'b0;
          state_d   = IDLE;
          if (bus.aeoi && !spurious_q) aeoiMask = 8'h01 << level_q;
        end
      end
      default: begin
        state_d   = IDLE;
        intOut_d  = 1'b0;
        dataOe_d  = 1'b0;
        dataOut_d = 8'h00;
      end
    endcase
  end

  assign intDone_d = eoiMask | aeoiMask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      intaPrev_q <= 1'b1;
      level_q    <= 3'd0;
      spurious_q <= 1'b0;
      intOut_q   <= 1'b0;
      dataOe_q   <= 1'b0;
      dataOut_q  <= 8'h00;
      isrSet_q   <= 8'h00;
      irrClr_q   <= 8'h00;
      intDone_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      intaPrev_q <= bus.inta_n;
      level_q    <= level_d;
      spurious_q <= spurious_d;
      intOut_q   <= intOut_d;
      dataOe_q   <= dataOe_d;
      dataOut_q  <= dataOut_d;
      isrSet_q   <= isrSet_d;
      irrClr_q   <= irrClr_d;
      intDone_q  <= intDone_d;
    end
  end

  assign bus.int_out  = intOut_q;
  assign bus.data_oe  = dataOe_q;
  assign bus.data_out = dataOut_q;
  assign bus.isr_set  = isrSet_q;
  assign bus.irr_clr  = irrClr_q;
  assign bus.int_done = intDone_q;
endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: an INTA-edge-counting model checked every cycle,
// plus literal expectations for the classic acknowledge and EOI scenarios.
module tb_inta_sequencer;
  logic clk;
  logic rst_n;
  int   testsRun;
  int   failCount;
  bit   checkEn;

  inta_sequencer_if seqBus ();

  inta_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (seqBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an interrupt cycle is active from request acceptance until the fourth INTA edge.
  bit         mActive = 1'b0;
  int         mEdges  = 0;
  logic       mPrev   = 1'b1;
  logic [2:0] mLevel  = 3'd0;
  bit         mSpur   = 1'b0;
  logic [4:0] mVec    = 5'd0;
  logic       eIntOut = 1'b0;
  logic       eOe     = 1'b0;
  logic [7:0] eData   = 8'h00;
  logic [7:0] eIsrSet = 8'h00;
  logic [7:0] eIrrClr = 8'h00;
  logic [7:0] eIntDone = 8'h00;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    logic       fell, rose;
    logic [7:0] aeoiBits, eoiBits;
    if (!rst_n) begin
      mActive = 1'b0; mEdges = 0; mPrev = 1'b1; mLevel = 3'd0; mSpur = 1'b0;
      eIntOut = 1'b0; eOe = 1'b0; eData = 8'h00;
      eIsrSet = 8'h00; eIrrClr = 8'h00; eIntDone = 8'h00;
      return;
    end
    fell = mPrev & ~seqBus.inta_n;
    rose = ~mPrev & seqBus.inta_n;
    eIsrSet = 8'h00;
    eIrrClr = 8'h00;
    aeoiBits = 8'h00;
    if (!mActive) begin
      if (seqBus.irr_req != 8'h00) begin
        mActive = 1'b1;
        mEdges  = 0;
      end
    end else if ((mEdges % 2 == 0 && fell) || (mEdges % 2 == 1 && rose)) begin
      mEdges++;
      if (mEdges == 1) begin
        mSpur = (seqBus.irr_req == 8'h00);
        mLevel = 3'd7;
        for (int i = 0; i < 8; i++) begin
          if (seqBus.irr_req[i]) begin
            mLevel = 3'(i);
            break;
          end
        end
        eIsrSet = seqBus.irr_req;
        eIrrClr = seqBus.irr_req;
      end else if (mEdges == 3) begin
        mVec = seqBus.icw2_vec;
      end else if (mEdges == 4) begin
        mActive = 1'b0;
        if (seqBus.aeoi && !mSpur) aeoiBits = 8'h01 << mLevel;
      end
    end
    eoiBits = 8'h00;
    if (seqBus.seoi_cmd) begin
      eoiBits = 8'h01 << seqBus.seoi_level;
    end else if (seqBus.eoi_cmd) begin
      for (int i = 0; i < 8; i++) begin
        if (seqBus.isr_in[i]) begin
          eoiBits[i] = 1'b1;
          break;
        end
      end
    end
    eIntDone = aeoiBits | eoiBits;
    eIntOut  = mActive && mEdges == 0;
    eOe      = mActive && mEdges == 3;
    eData    = eOe ? {mVec, mLevel} : 8'h00;
    mPrev    = seqBus.inta_n;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("model int_out",  8'(seqBus.int_out), 8'(eIntOut));
        checkOutput("model data_oe",  8'(seqBus.data_oe), 8'(eOe));
        checkOutput("model data_out", seqBus.data_out, eData);
        checkOutput("model isr_set",  seqBus.isr_set,  eIsrSet);
        checkOutput("model irr_clr",  seqBus.irr_clr,  eIrrClr);
        checkOutput("model int_done", seqBus.int_done, eIntDone);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // Full two-pulse acknowledge; optional early request withdrawal and SEOI on the final rise.
  task automatic applyStimulus(input logic [7:0] req, input logic [4:0] vec, input bit ae,
                               input bit dropReq, input bit seoiAtEnd,
                               input logic [7:0] expSet, input logic [7:0] expData,
                               input logic [7:0] expDone);
    seqBus.irr_req  = req;
    seqBus.icw2_vec = vec;
    seqBus.aeoi     = ae;
    step(1);
    checkOutput("int_out latency", 8'(seqBus.int_out), 8'h01);
    if (dropReq) begin
      seqBus.irr_req = 8'h00;
      step(2);
    end else begin
      step(1);
    end
    seqBus.inta_n = 1'b0;
    step(1);
    checkOutput("isr_set at fall", seqBus.isr_set, expSet);
    checkOutput("irr_clr at fall", seqBus.irr_clr, expSet);
    checkOutput("int_out dropped", 8'(seqBus.int_out), 8'h00);
    seqBus.irr_req = 8'h00;
    step(1);
    checkOutput("isr_set one cycle", seqBus.isr_set, 8'h00);
    seqBus.inta_n = 1'b1;
    step(2);
    seqBus.inta_n = 1'b0;
    step(1);
    checkOutput("data_oe second inta", 8'(seqBus.data_oe), 8'h01);
    checkOutput("data_out vector", seqBus.data_out, expData);
    step(1);
    checkOutput("data_out held", seqBus.data_out, expData);
    seqBus.inta_n = 1'b1;
    if (seoiAtEnd) begin
      seqBus.seoi_cmd   = 1'b1;
      seqBus.seoi_level = 3'd6;
    end
    step(1);
    seqBus.seoi_cmd = 1'b0;
    checkOutput("int_done after rise", seqBus.int_done, expDone);
    checkOutput("data_oe released", 8'(seqBus.data_oe), 8'h00);
    step(1);
    checkOutput("int_done one cycle", seqBus.int_done, 8'h00);
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    checkEn   = 1'b0;
    rst_n     = 1'b0;
    seqBus.irr_req    = 8'h00;
    seqBus.inta_n     = 1'b1;
    seqBus.icw2_vec   = 5'h00;
    seqBus.aeoi       = 1'b0;
    seqBus.eoi_cmd    = 1'b0;
    seqBus.seoi_cmd   = 1'b0;
    seqBus.seoi_level = 3'd0;
    seqBus.isr_in     = 8'h00;
    #12;
    checkOutput("reset int_out",  8'(seqBus.int_out), 8'h00);
    checkOutput("reset data_oe",  8'(seqBus.data_oe), 8'h00);
    checkOutput("reset data_out", seqBus.data_out, 8'h00);
    checkOutput("reset int_done", seqBus.int_done, 8'h00);
    checkEn = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(2);
    checkOutput("idle no int_out", 8'(seqBus.int_out), 8'h00);

    applyStimulus(8'h08, 5'h11, 1'b0, 1'b0, 1'b0, 8'h08, 8'h8B, 8'h00);
    step(2);
    applyStimulus(8'h08, 5'h11, 1'b1, 1'b0, 1'b0, 8'h08, 8'h8B, 8'h08);
    applyStimulus(8'h08, 5'h11, 1'b1, 1'b1, 1'b0, 8'h00, 8'h8F, 8'h00);

    seqBus.isr_in  = 8'h24;
    seqBus.eoi_cmd = 1'b1;
    step(1);
    seqBus.eoi_cmd = 1'b0;
    checkOutput("eoi lowest isr", seqBus.int_done, 8'h04);
    step(1);
    checkOutput("eoi one cycle", seqBus.int_done, 8'h00);
    seqBus.eoi_cmd    = 1'b1;
    seqBus.seoi_cmd   = 1'b1;
    seqBus.seoi_level = 3'd5;
    step(1);
    seqBus.eoi_cmd  = 1'b0;
    seqBus.seoi_cmd = 1'b0;
    checkOutput("seoi wins", seqBus.int_done, 8'h20);
    step(1);

    applyStimulus(8'h08, 5'h11, 1'b1, 1'b0, 1'b1, 8'h08, 8'h8B, 8'h48);

    seqBus.irr_req  = 8'h20;
    seqBus.icw2_vec = 5'h0A;
    seqBus.aeoi     = 1'b1;
    step(2);
    seqBus.inta_n = 1'b0;
    step(1);
    seqBus.irr_req = 8'h00;
    step(1);
    seqBus.inta_n = 1'b1;
    step(2);
    seqBus.inta_n = 1'b0;
    step(2);
    checkOutput("ack2 before reset", 8'(seqBus.data_oe), 8'h01);
    rst_n = 1'b0;
    #1;
    checkOutput("reset data_oe now",  8'(seqBus.data_oe), 8'h00);
    checkOutput("reset data_out now", seqBus.data_out, 8'h00);
    checkOutput("reset int_out now",  8'(seqBus.int_out), 8'h00);
    seqBus.inta_n = 1'b1;
    step(2);
    checkOutput("reset no int_done", seqBus.int_done, 8'h00);
    rst_n = 1'b1;
    step(3);
    checkOutput("restart needs req", 8'(seqBus.int_out), 8'h00);
    applyStimulus(8'h02, 5'h1F, 1'b0, 1'b0, 1'b0, 8'h02, 8'hF9, 8'h00);
    step(2);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
